// File: rtl/intr_pkg.sv
// Shared types and helpers for the MSI interrupt generator.
package intr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int MSI_DATA_W = 16;
  localparam int MME_MAX    = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/intr_fifo.sv
// Pending-vector queue: sync FIFO with first-word-fall-through read data.
module intr_fifo
  import intr_pkg::*;
#(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 8,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop & ~empty;
  // A full queue still takes a push when a pop frees a slot on the same edge.
  assign push_en = push & (~full | pop_en);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/intr_msi_gen.sv
// Turns prioritiser vector pulses into queued MSI write requests
// on a valid/ready master port.
module intr_msi_gen
  import intr_pkg::*;
#(
  parameter  int PORTS      = 32,
  parameter  int FIFO_DEPTH = 8,
  parameter  int ADDR_WIDTH = 64,
  parameter  int DATA_WIDTH = 32,
  localparam int NUM_W      = clog2(PORTS),
  localparam int CNT_W      = clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  intr_vec_req,
  input  logic [NUM_W-1:0]      intr_num,
  input  logic                  cfg_msi_en,
  input  logic [ADDR_WIDTH-1:0] cfg_msi_addr,
  input  logic [15:0]           cfg_msi_data,
  input  logic [2:0]            cfg_msi_mme,
  input  logic                  ovf_clr,
  output logic                  m_wr_valid,
  input  logic                  m_wr_ready,
  output logic [ADDR_WIDTH-1:0] m_wr_addr,
  output logic [DATA_WIDTH-1:0] m_wr_data,
  output logic [CNT_W-1:0]      pend_count,
  output logic                  ovf_pulse,
  output logic                  ovf_sticky
);

  function automatic logic [MSI_DATA_W-1:0] msi_data16(
    input logic [MSI_DATA_W-1:0] base,
    input logic [NUM_W-1:0]      vec,
    input logic [2:0]            mme
  );
    logic [2:0]            eff;
    logic [MSI_DATA_W-1:0] mask;
    eff  = (mme > 3'(MME_MAX)) ? 3'(MME_MAX) : mme;
    mask = (MSI_DATA_W'(1) << eff) - MSI_DATA_W'(1);
    return (base & ~mask) | (MSI_DATA_W'(vec) & mask);
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic             req_d;
  logic             push;
  logic             load;
  logic             can_pop;
  logic             full;
  logic             empty;
  logic             drop;
  logic [NUM_W-1:0] head;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cfg_msi_addr[1:0];

  assign push    = intr_vec_req & ~req_d;
  assign can_pop = ~empty & cfg_msi_en;
  assign drop    = push & full & ~load;

  intr_fifo #(
    .WIDTH (NUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (intr_num),
    .pop   (load),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (pend_count)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_pop) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_wr_ready) begin
          if (can_pop) load = 1'b1;
          else state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_d      <= 1'b0;
      m_wr_valid <= 1'b0;
      m_wr_addr  <= '0;
      m_wr_data  <= '0;
      ovf_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_d      <= intr_vec_req;
      m_wr_valid <= (state_d == SEND);
      ovf_pulse  <= drop;
      // A drop on the clearing edge keeps the flag set.
      if (drop)         ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
      if (load) begin
        m_wr_addr <= {cfg_msi_addr[ADDR_WIDTH-1:2], 2'b00};
        m_wr_data <= {{(DATA_WIDTH - MSI_DATA_W){1'b0}},
                      msi_data16(cfg_msi_data, head, cfg_msi_mme)};
      end
    end
  end

endmodule
